// File: rtl/rram_access_sequencer.sv
// Host-side initiator for the RRAM array controller.
// Queues requests in a 2-deep FIFO and issues one EN pulse per operation.
module rram_access_sequencer #(
  parameter int B_SIZE    = 4,
  parameter int X_SIZE    = 4,
  parameter int Y_SIZE    = 6,
  parameter int RD_CYCLES = 3,
  parameter int WR_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_RW,
  input  logic [X_SIZE-1:0] REQ_X,
  input  logic [Y_SIZE-1:0] REQ_Y,
  input  logic [B_SIZE-1:0] REQ_WDATA,
  output logic              EN,
  output logic              RW,
  output logic [X_SIZE-1:0] X_ADDRESS,
  output logic [Y_SIZE-1:0] Y_ADDRESS,
  output logic [B_SIZE-1:0] WDATA,
  input  logic [B_SIZE-1:0] SA_DATA,
  output logic [B_SIZE-1:0] RD_DATA,
  output logic              RD_VALID,
  output logic              BUSY
);

  localparam int MAXC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam int EW   = 1 + X_SIZE + Y_SIZE + B_SIZE;

  localparam logic [CW-1:0] RD_LOAD = CW'(RD_CYCLES - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WR_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [EW-1:0] mem [2];
  logic [EW-1:0] head;
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic          push;
  logic          pop;

  assign REQ_READY = (count < 2'd2);
  assign push      = REQ_VALID && REQ_READY;
  assign pop       = (state == S_IDLE) && (count != 2'd0);
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {REQ_RW, REQ_X, REQ_Y, REQ_WDATA};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Pop only from IDLE, so every operation is followed by an IDLE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      EN        <= 1'b0;
      BUSY      <= 1'b0;
      RW        <= 1'b0;
      X_ADDRESS <= '0;
      Y_ADDRESS <= '0;
      WDATA     <= '0;
      RD_DATA   <= '0;
      RD_VALID  <= 1'b0;
    end else begin
      EN       <= 1'b0;
      RD_VALID <= 1'b0;
      unique case (state)
        S_IDLE: begin
          BUSY <= 1'b0;
          if (pop) begin
            {RW, X_ADDRESS, Y_ADDRESS, WDATA} <= head;
            EN    <= 1'b1;
            BUSY  <= 1'b1;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= RW ? RD_LOAD : WR_LOAD;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state <= S_IDLE;
            BUSY  <= 1'b0;
            if (RW) begin
              RD_DATA  <= SA_DATA;
              RD_VALID <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rram_access_sequencer.sv
// Bench for rram_access_sequencer: schedule-based model plus
// directed scenarios with literal expectations.
module tb_rram_access_sequencer;

  typedef struct packed {
    logic       rw;
    logic [3:0] x;
    logic [5:0] y;
    logic [3:0] wd;
  } req_t;

  logic       clk;
  logic       reset;
  logic       REQ_VALID;
  logic       REQ_READY;
  logic       REQ_RW;
  logic [3:0] REQ_X;
  logic [5:0] REQ_Y;
  logic [3:0] REQ_WDATA;
  logic       EN;
  logic       RW;
  logic [3:0] X_ADDRESS;
  logic [5:0] Y_ADDRESS;
  logic [3:0] WDATA;
  logic [3:0] SA_DATA;
  logic [3:0] RD_DATA;
  logic       RD_VALID;
  logic       BUSY;

  rram_access_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_RW    (REQ_RW),
    .REQ_X     (REQ_X),
    .REQ_Y     (REQ_Y),
    .REQ_WDATA (REQ_WDATA),
    .EN        (EN),
    .RW        (RW),
    .X_ADDRESS (X_ADDRESS),
    .Y_ADDRESS (Y_ADDRESS),
    .WDATA     (WDATA),
    .SA_DATA   (SA_DATA),
    .RD_DATA   (RD_DATA),
    .RD_VALID  (RD_VALID),
    .BUSY      (BUSY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  // Model: each op occupies its issue cycle plus its phase count,
  // and the next issue may start no sooner than two cycles later.
  int   k = 0;
  req_t q[$];
  int   free_edge;
  int   busy_end;
  int   cap_edge;
  bit   started = 0;
  logic e_en, e_busy, e_ready, e_rdv, e_rw;
  logic [3:0] e_x, e_wd, e_rdd;
  logic [5:0] e_y;

  task automatic model_step();
    req_t r;
    int   c;
    bit   pushed;
    k++;
    if (reset) begin
      q.delete();
      free_edge = 0;
      busy_end  = -1;
      cap_edge  = -1;
      e_en = 0; e_busy = 0; e_rdv = 0; e_rw = 0;
      e_x = 0; e_y = 0; e_wd = 0; e_rdd = 0;
      e_ready = 1;
      started = 1;
    end else if (started) begin
      pushed = REQ_VALID && (q.size() < 2);
      e_en = 0;
      if (q.size() > 0 && k >= free_edge) begin
        r = q.pop_front();
        c = r.rw ? 3 : 1;
        e_en = 1;
        e_rw = r.rw; e_x = r.x; e_y = r.y; e_wd = r.wd;
        busy_end  = k + c;
        free_edge = k + c + 2;
        cap_edge  = r.rw ? k + c + 1 : -1;
      end
      e_busy = (k <= busy_end);
      e_rdv  = (k == cap_edge);
      if (e_rdv) e_rdd = SA_DATA;
      if (pushed) q.push_back(req_t'({REQ_RW, REQ_X, REQ_Y, REQ_WDATA}));
      e_ready = (q.size() < 2);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("en",      EN,        e_en);
      chk("busy",    BUSY,      e_busy);
      chk("ready",   REQ_READY, e_ready);
      chk("rd_valid",RD_VALID,  e_rdv);
      chk("rd_data", RD_DATA,   e_rdd);
      chk("rw",      RW,        e_rw);
      chk("x_addr",  X_ADDRESS, e_x);
      chk("y_addr",  Y_ADDRESS, e_y);
      chk("wdata",   WDATA,     e_wd);
    end
  end

  int cyc = 0;
  int en_cyc[$];
  logic [3:0] en_x[$];
  int rdv_n = 0;
  bit saw_full = 0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (EN === 1'b1) begin
      en_cyc.push_back(cyc);
      en_x.push_back(X_ADDRESS);
    end
    if (RD_VALID === 1'b1) rdv_n++;
    if (started && REQ_READY === 1'b0) saw_full = 1;
  end

  bit sa_walk = 0;

  task automatic tick();
    @(negedge clk);
    #1;
    if (sa_walk) SA_DATA = SA_DATA + 4'd3;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Leaves REQ_VALID high; returns in the cycle after the accepting edge.
  task automatic send(logic rw, logic [3:0] x, logic [5:0] y, logic [3:0] wd);
    int b;
    REQ_VALID = 1'b1;
    REQ_RW    = rw;
    REQ_X     = x;
    REQ_Y     = y;
    REQ_WDATA = wd;
    b = 0;
    while (REQ_READY !== 1'b1 && b < 50) begin
      tick();
      b++;
    end
    if (b >= 50) chk("accept_timeout", 0, 1);
    tick();
  endtask

  task automatic drop();
    REQ_VALID = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t actual=running required=done", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    REQ_VALID = 0; REQ_RW = 0; REQ_X = 0; REQ_Y = 0; REQ_WDATA = 0;
    SA_DATA = 4'h0;
    idle(3);
    chk("lit_rst_en",    EN,        0);
    chk("lit_rst_ready", REQ_READY, 1);
    chk("lit_rst_busy",  BUSY,      0);
    chk("lit_rst_rdv",   RD_VALID,  0);
    reset = 1'b0;
    idle(2);

    // Single write
    send(0, 4'd2, 6'd4, 4'hA);
    drop();
    chk("lit_w_en0", EN, 0);
    tick();
    chk("lit_w_en1",  EN,        1);
    chk("lit_w_rw",   RW,        0);
    chk("lit_w_x",    X_ADDRESS, 2);
    chk("lit_w_y",    Y_ADDRESS, 4);
    chk("lit_w_wd",   WDATA,     4'hA);
    chk("lit_w_busy1",BUSY,      1);
    tick();
    chk("lit_w_en2",  EN,   0);
    chk("lit_w_busy2",BUSY, 1);
    chk("lit_w_wd2",  WDATA,4'hA);
    tick();
    chk("lit_w_busy3",BUSY,     0);
    chk("lit_w_rdv",  RD_VALID, 0);
    idle(2);

    // Single read
    SA_DATA = 4'h5;
    send(1, 4'd15, 6'd63, 4'h0);
    drop();
    tick();
    chk("lit_r_en", EN, 1);
    chk("lit_r_rw", RW, 1);
    idle(3);
    chk("lit_r_rdv_early", RD_VALID, 0);
    tick();
    chk("lit_r_rdv",  RD_VALID, 1);
    chk("lit_r_data", RD_DATA,  4'h5);
    SA_DATA = 4'h9;
    tick();
    chk("lit_r_rdv_off", RD_VALID, 0);
    chk("lit_r_hold",    RD_DATA,  4'h5);
    idle(3);

    // Back-to-back W, R, R
    en_cyc.delete();
    rdv_n = 0;
    saw_full = 0;
    sa_walk = 1;
    send(0, 4'd1, 6'd1, 4'h1);
    send(1, 4'd2, 6'd2, 4'h0);
    send(1, 4'd3, 6'd3, 4'h0);
    drop();
    idle(20);
    sa_walk = 0;
    chk("lit_b2b_full", saw_full, 1);
    chk("lit_b2b_nen", en_cyc.size(), 3);
    if (en_cyc.size() == 3) begin
      chk("lit_b2b_gap0", en_cyc[1] - en_cyc[0], 3);
      chk("lit_b2b_gap1", en_cyc[2] - en_cyc[1], 5);
    end
    chk("lit_b2b_rdv", rdv_n, 2);

    // Valid held through full FIFO
    en_x.delete();
    for (int i = 4; i < 8; i++) send(0, 4'(i), 6'(i), 4'(i));
    drop();
    idle(16);
    chk("lit_full_n", en_x.size(), 4);
    if (en_x.size() == 4) begin
      chk("lit_full_x0", en_x[0], 4);
      chk("lit_full_x1", en_x[1], 5);
      chk("lit_full_x2", en_x[2], 6);
      chk("lit_full_x3", en_x[3], 7);
    end

    // Reset during read WAIT with one request queued
    SA_DATA = 4'hC;
    send(1, 4'd8, 6'd8, 4'h0);
    send(0, 4'd9, 6'd9, 4'h2);
    drop();
    idle(2);
    reset = 1'b1;
    tick();
    chk("lit_mr_en",    EN,        0);
    chk("lit_mr_busy",  BUSY,      0);
    chk("lit_mr_ready", REQ_READY, 1);
    chk("lit_mr_rdv",   RD_VALID,  0);
    reset = 1'b0;
    en_cyc.delete();
    rdv_n = 0;
    idle(12);
    chk("lit_mr_no_en",  en_cyc.size(), 0);
    chk("lit_mr_no_rdv", rdv_n, 0);

    // Corner addresses
    en_x.delete();
    SA_DATA = 4'h6;
    send(1, 4'd0,  6'd0,  4'h0); drop(); idle(6);
    send(0, 4'd0,  6'd63, 4'hF); drop(); idle(6);
    send(1, 4'd15, 6'd0,  4'h0); drop(); idle(6);
    send(0, 4'd15, 6'd63, 4'h3); drop(); idle(6);
    chk("lit_corner_n", en_x.size(), 4);
    if (en_x.size() == 4) begin
      chk("lit_corner_x0", en_x[0], 0);
      chk("lit_corner_x3", en_x[3], 15);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
